// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single 1-bit full-adder cell. A carry flop links each bit to the next.
// Optional build macro SERIAL_ADD_OVERFLOW_EN adds the ovf_o output.
// When the macro is defined, ovf_o reports signed two's-complement overflow.
//
//   state | meaning
//   IDLE  | ready_o high; waiting for start_i
//   RUN   | busy_o high; one bit of the sum is produced per clock
//   DONE  | done_o high for one cycle; sum_o/cout_o hold the new result
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADD_OVERFLOW_EN
  output logic             ovf_o,
`endif
  output logic             cout_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] sr_d;

  // Shared full-adder cell fed from the operand LSBs and the stored carry.
  assign cell_s = sa_q[0] ^ sb_q[0] ^ cy_q;
  assign cell_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & cy_q) | (sb_q[0] & cy_q);
  assign sr_d   = {cell_s, sr_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_OVERFLOW_EN
  logic ovf_q;

  // Overflow flag captured on the final bit: carry into MSB vs carry out of MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST_BIT) begin
      ovf_q <= cy_q ^ cell_c;
    end
  end

  assign ovf_o = ovf_q;
`endif

  // Sequencer: operand capture, bit-serial shifting and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sa_q    <= a_i;
            sb_q    <= b_i;
            cy_q    <= cin_i;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sr_q  <= sr_d;
          cy_q  <= cell_c;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            sum_q   <= sr_d;
            cout_q  <= cell_c;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8).
// When SERIAL_ADD_OVERFLOW_EN is defined, the bench also checks ovf_o.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
`ifdef SERIAL_ADD_OVERFLOW_EN
    .ovf_o   (ovf),
`endif
    .cout_o  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_checks++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADD_OVERFLOW_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  // One full addition with busy/latency/hold checks and result compare.
  task automatic test_add(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] es, input logic ec, input logic eo);
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    int           n;
    int           busy_bad;
    prev_sum  = sum;
    prev_cout = cout;
    a = av; b = bv; cin = cv; start = 1'b1;
    step();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    n = 0;
    busy_bad = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1 || ready !== 1'b0 || sum !== prev_sum || cout !== prev_cout) busy_bad++;
      step();
      n++;
    end
    n_checks++;
    if (n != W) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, n, W); end
    n_checks++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL %s_run_flags bad_cycles=%0d exp=0", nm, busy_bad); end
    n_checks++;
    if (sum !== es) begin n_fail++; $display("FAIL %s_sum got=%h exp=%h", nm, sum, es); end
    n_checks++;
    if (cout !== ec) begin n_fail++; $display("FAIL %s_cout got=%b exp=%b", nm, cout, ec); end
`ifdef SERIAL_ADD_OVERFLOW_EN
    n_checks++;
    if (ovf !== eo) begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, eo); end
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", nm);
`endif
    step();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || sum !== es) begin
      n_fail++;
      $display("FAIL %s_after_done done=%b ready=%b sum=%h exp done=0 ready=1 sum=%h", nm, done, ready, sum, es);
    end
  endtask

  task automatic test_start_during_run();
    int pulses;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin start = 1'b1; a = 8'hAA; end
      else if (i == 3) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        n_checks++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
          n_fail++; $display("FAIL ignore_start_result sum=%h cout=%b exp sum=30 cout=0", sum, cout);
        end
      end
      step();
    end
    start = 1'b0;
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ignore_start_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done);
    end
    n_checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_result sum=%h cout=%b exp sum=00 cout=0", sum, cout);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
    test_add("fresh", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_start_during_run();
    test_reset_mid_op();
    test_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    test_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_add("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that reuses one 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. Latches operands on a start/ready handshake and sequences the cell with a bit counter and carry flip-flop. Presents a registered sum and carry-out with a one-cycle done pulse. Used where area matters more than latency in the lab arithmetic datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only while ready=1
a  input  WIDTH  operand A; sampled on the accepted start edge
b  input  WIDTH  operand B; sampled on the accepted start edge
cin  input  1  carry-in; sampled on the accepted start edge
ready  output  1  high in IDLE; start accepted only when high
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result is valid
sum  output  WIDTH  registered result; held until next accepted start
cout  output  1  registered carry-out; held with sum

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Bit cell equations: s = a_i ^ b_i ^ c; c_next = (a_i & b_i) | (a_i & c) | (b_i & c). Cell is combinational; carry stored in a flip-flop between bits.
- Internal state: FSM {IDLE, RUN, DONE}; operand shift regs sa, sb (WIDTH); result shift reg sr (WIDTH); carry flop cy; bit counter cnt, width ceil(log2(WIDTH)).
- Reset (rst=1 at edge): state=IDLE, sa=sb=sr=0, cy=0, cnt=0, sum=0, cout=0, done=0, busy=0, ready=1. Reset wins over every other event, including mid-RUN (operation aborted, no done pulse).
- IDLE: ready=1. On edge with start=1: sa<=a, sb<=b, cy<=cin, cnt<=0, state<=RUN. start=0: stay.
- RUN: busy=1, ready=0. Each edge: sr <= {s, sr[WIDTH-1:1]}; cy <= c_next; sa, sb shift right by 1 (zero fill); cnt<=cnt+1. Cell inputs are sa[0], sb[0], cy. When cnt==WIDTH-1 on that edge: state<=DONE, sum<={s, sr[WIDTH-1:1]}, cout<=c_next.
- DONE: done=1 for exactly one cycle, ready=0, busy=0; next edge -> IDLE.
- Latency: start accepted at edge 0; RUN occupies edges 1..WIDTH; done high in the cycle after edge WIDTH; new start earliest accepted at edge WIDTH+2.
- start while RUN or DONE: ignored, not queued. Operand changes after acceptance: no effect.
- sum/cout are unchanged from the previous result during RUN and DONE-transition; update only on entry to DONE.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- ready, busy, done decode from registered state only (no combinational path from start).

Optional Feature:
Macro SERIAL_ADD_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), signed two's-complement overflow = carry into MSB XOR carry out of MSB, captured on entry to DONE together with sum; reset value 0; held until next DONE.
- Not defined: port ovf absent; no overflow logic synthesized; all other behaviour identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ready=1, busy=0, done=0, sum=0x00, cout=0.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy for 8 cycles, done pulse at cycle 9, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start during RUN: begin 0x10+0x20, assert start with a=0xAA at cycle 3 -> ignored, result sum=0x30, cout=0, exactly one done pulse.
- Reset mid-op: start 0x0F+0x0F, rst=1 at cycle 4 -> next cycle ready=1, sum=0x00, no done pulse; fresh start 0x01+0x02 -> sum=0x03.
- With SERIAL_ADD_OVERFLOW_EN: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x05+0x03 -> ovf=0.
